// File: rtl/mac_sram_sequencer.sv
// rtl/mac_sram_sequencer.sv - loads two operand SRAMs from a byte stream, then replays operand pairs to a MAC
module mac_sram_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_wr_valid,
  input  logic [7:0]    i_wr_data,
  output logic          o_wr_ready,
  output logic          o_cs_a_n,
  output logic          o_cs_b_n,
  output logic          o_we_n,
  output logic          o_oe_n,
  output logic [AW-1:0] o_addr,
  output logic [7:0]    o_io_out,
  output logic          o_io_oe,
  input  logic [7:0]    i_io_in,
  output logic          o_mac_valid,
  output logic [7:0]    o_opa,
  output logic [7:0]    o_opb,
  input  logic          i_mac_ready,
  output logic          o_mac_clr,
  output logic          o_done,
  output logic [2:0]    o_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    RD_A   = 3'd3,
    RD_B   = 3'd4,
    ISSUE  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic          strobe;

  assign o_state = state;
  assign o_addr  = cnt;

  // All SRAM controls are registered so they are glitch-free at the pins.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      strobe      <= 1'b0;
      o_wr_ready  <= 1'b0;
      o_cs_a_n    <= 1'b1;
      o_cs_b_n    <= 1'b1;
      o_we_n      <= 1'b1;
      o_oe_n      <= 1'b1;
      o_io_out    <= 8'h00;
      o_io_oe     <= 1'b0;
      o_mac_valid <= 1'b0;
      o_opa       <= 8'h00;
      o_opb       <= 8'h00;
      o_mac_clr   <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_mac_clr <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state      <= LOAD_A;
            cnt        <= '0;
            o_done     <= 1'b0;
            o_wr_ready <= 1'b1;
          end
        end
        LOAD_A, LOAD_B: begin
          if (strobe) begin
            strobe   <= 1'b0;
            o_cs_a_n <= 1'b1;
            o_cs_b_n <= 1'b1;
            o_we_n   <= 1'b1;
            o_io_oe  <= 1'b0;
            if (cnt == LAST) begin
              cnt <= '0;
              if (state == LOAD_A) begin
                state      <= LOAD_B;
                o_wr_ready <= 1'b1;
              end else begin
                // First read of the compute phase: clear the accumulator alongside it.
                state      <= RD_A;
                o_wr_ready <= 1'b0;
                o_cs_a_n   <= 1'b0;
                o_oe_n     <= 1'b0;
                o_mac_clr  <= 1'b1;
              end
            end else begin
              cnt        <= cnt + AW'(1);
              o_wr_ready <= 1'b1;
            end
          end else if (i_wr_valid && o_wr_ready) begin
            strobe     <= 1'b1;
            o_wr_ready <= 1'b0;
            o_io_out   <= i_wr_data;
            o_we_n     <= 1'b0;
            o_io_oe    <= 1'b1;
            if (state == LOAD_A) o_cs_a_n <= 1'b0;
            else                 o_cs_b_n <= 1'b0;
          end
        end
        RD_A: begin
          o_opa    <= i_io_in;
          o_cs_a_n <= 1'b1;
          o_cs_b_n <= 1'b0;
          state    <= RD_B;
        end
        RD_B: begin
          o_opb       <= i_io_in;
          o_cs_b_n    <= 1'b1;
          o_oe_n      <= 1'b1;
          o_mac_valid <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (i_mac_ready) begin
            o_mac_valid <= 1'b0;
            if (cnt == LAST) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              cnt      <= cnt + AW'(1);
              state    <= RD_A;
              o_cs_a_n <= 1'b0;
              o_oe_n   <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sram_sequencer.sv
// tb/tb_mac_sram_sequencer.sv - directed bench with SRAM models and operand-pair scoreboard
module tb_mac_sram_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       cs_a_n, cs_b_n, we_n, oe_n;
  logic [3:0] addr;
  logic [7:0] io_out;
  logic       io_oe;
  logic [7:0] io_in;
  logic       mac_valid;
  logic [7:0] opa, opb;
  logic       mac_ready = 1'b0;
  logic       mac_clr, done;
  logic [2:0] state;

  mac_sram_sequencer #(.DEPTH(16), .AW(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_wr_valid(wr_valid), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .o_cs_a_n(cs_a_n), .o_cs_b_n(cs_b_n), .o_we_n(we_n), .o_oe_n(oe_n),
    .o_addr(addr), .o_io_out(io_out), .o_io_oe(io_oe), .i_io_in(io_in),
    .o_mac_valid(mac_valid), .o_opa(opa), .o_opb(opb), .i_mac_ready(mac_ready),
    .o_mac_clr(mac_clr), .o_done(done), .o_state(state)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int wr_strobes = 0;
  int xfers = 0;
  int clr_cnt = 0;
  int wa_cnt [16];
  logic [7:0]  mem_a [16];
  logic [7:0]  mem_b [16];
  logic [7:0]  va [16];
  logic [7:0]  vb [16];
  logic [15:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SRAM models: write on the edge closing a strobe, combinational read.
  always @(posedge clk) begin
    if (rst && !we_n && !cs_a_n) begin mem_a[addr] = io_out; wa_cnt[addr]++; end
    if (rst && !we_n && !cs_b_n) mem_b[addr] = io_out;
  end
  always_comb begin
    io_in = 8'h00;
    if (!oe_n && !cs_a_n) io_in = mem_a[addr];
    else if (!oe_n && !cs_b_n) io_in = mem_b[addr];
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("inv_cs", {31'd0, cs_a_n | cs_b_n}, 1);
      chk("inv_we_oe", {31'd0, we_n | oe_n}, 1);
      chk("inv_io_oe", {31'd0, io_oe & we_n}, 0);
      chk("inv_valid", {31'd0, mac_valid & (state != 3'd5)}, 0);
      if (!we_n) wr_strobes++;
      if (mac_clr) clr_cnt++;
      if (mac_valid && mac_ready) begin
        if (sb.size() == 0) chk("sb_underflow", {16'd0, opa, opb}, 32'hFFFF_FFFF);
        else chk("pair", {16'd0, opa, opb}, {16'd0, sb.pop_front()});
        xfers++;
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_ctl"}, {cs_a_n, cs_b_n, we_n, oe_n, io_oe}, 5'b11110);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_io_out"}, io_out, 0);
    chk({tag, "_ops"}, {opa, opb}, 0);
    chk({tag, "_flags"}, {wr_ready, mac_valid, mac_clr, done}, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load(input bit is_b, input bit stall, input bit push, input bit poke, input int stop_at);
    bit got;
    int waits;
    for (int k = 0; k < 16; k++) begin
      if (stall) repeat ($urandom_range(0, 2)) begin wr_valid = 1'b0; @(posedge clk); #1; end
      wr_valid = 1'b1;
      wr_data  = is_b ? vb[k] : va[k];
      if (poke && k == 5) start = 1'b1;
      got = 0;
      waits = 0;
      while (!got && waits < 20) begin
        @(negedge clk);
        waits++;
        if (wr_ready) begin @(posedge clk); #1; got = 1; end
      end
      start = 1'b0;
      wr_valid = 1'b0;
      chk("wr_handshake", {31'd0, got}, 1);
      if (!is_b && !stall) chk("ready_alt", waits, (k == 0) ? 1 : 2);
      if (push && is_b) sb.push_back({va[k], vb[k]});
      if (k == stop_at) return;
    end
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (!done && n < 800) begin
      @(posedge clk); #1;
      if (rnd) mac_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk("done_reached", {31'd0, done}, 1);
    mac_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sa, sbv;
    logic [3:0] saddr;
    int n;
    for (int i = 0; i < 16; i++) begin wa_cnt[i] = 0; mem_a[i] = 0; mem_b[i] = 0; end

    rst = 1'b1;
    #2 rst = 1'b0;
    #1 chk_reset("por");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Run 1: A=k, B=2k, start poked mid-load and mid-issue, initial ISSUE stall.
    for (int k = 0; k < 16; k++) begin va[k] = 8'(k); vb[k] = 8'(2 * k); end
    pulse_start();
    chk("run1_load_a", state, 1);
    load(0, 0, 0, 1, -1);
    @(posedge clk); #1;
    chk("run1_load_b", state, 2);
    chk("run1_a_strobes", wr_strobes, 16);
    for (int k = 0; k < 16; k++) begin
      chk("mem_a", mem_a[k], k);
      chk("mem_a_once", wa_cnt[k], 1);
    end
    load(1, 0, 1, 0, -1);
    n = 0;
    while (!mac_valid && n < 10) begin @(negedge clk); n++; end
    chk("issue_reached", {31'd0, mac_valid}, 1);
    sa = opa; sbv = opb; saddr = addr;
    chk("stall_first_pair", {sa, sbv}, {va[0], vb[0]});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i == 2);
      chk("stall_valid", {31'd0, mac_valid}, 1);
      chk("stall_ops", {opa, opb}, {sa, sbv});
      chk("stall_addr", addr, saddr);
    end
    start = 1'b0;
    @(posedge clk); #1;
    mac_ready = 1'b1;
    wait_done(0);
    chk("run1_state", state, 6);
    chk("run1_xfers", xfers, 16);
    chk("run1_clr", clr_cnt, 1);
    chk("run1_sb_empty", sb.size(), 0);
    chk("run1_idle_ctl", {cs_a_n, cs_b_n, we_n, oe_n, io_oe, mac_valid}, 6'b111100);

    // Run 2: reset during the third LOAD_B strobe.
    for (int k = 0; k < 16; k++) begin va[k] = 8'hA0 + 8'(k); vb[k] = 8'h50 + 8'(k); end
    pulse_start();
    load(0, 0, 0, 0, -1);
    load(1, 0, 0, 0, 2);
    @(negedge clk);
    chk("abort_mid_strobe", {we_n, cs_b_n, addr}, {2'b00, 4'd2});
    rst = 1'b0;
    #1 chk_reset("abort");
    @(posedge clk); #1;
    rst = 1'b1;
    pulse_start();
    chk("restart_state", state, 1);
    chk("restart_addr", addr, 0);
    chk("restart_ready", {31'd0, wr_ready}, 1);

    // Run 3: random data, random stalls on both handshakes.
    wr_strobes = 0; xfers = 0; clr_cnt = 0;
    sb.delete();
    for (int k = 0; k < 16; k++) begin va[k] = 8'($urandom); vb[k] = 8'($urandom); end
    load(0, 1, 0, 0, -1);
    load(1, 1, 1, 0, -1);
    wait_done(1);
    repeat (2) @(posedge clk);
    #1;
    chk("run3_strobes", wr_strobes, 32);
    chk("run3_xfers", xfers, 16);
    chk("run3_clr", clr_cnt, 1);
    chk("run3_sb_empty", sb.size(), 0);
    chk("run3_state", state, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
